bram_bist: RTL and testbench
============================

# bram_bist

March-test BIST engine that drives the block-RAM primitive from the initiator side. It generates write enable, write/read addresses and write data, consumes the RAM read data, and checks every readback. It reports pass/fail plus the first failing address and data word. It sits beside each `ram` instance in pcbfpga test designs and is wired port-for-port to the RAM's `WE`/`ADDR`/`ADDR2`/`DIN`/`DOUT`.

## Interface
- `DATA_WIDTH`, 5: RAM word width.
- `ADDR_WIDTH`, 10: RAM address width; depth N = 2^ADDR_WIDTH.
- `SYNC_READ`, 1: read latency of the attached RAM; 1 = registered DOUT, 0 = combinational DOUT.
- `STOP_ON_FAIL`, 1: 1 = abort at first miscompare; 0 = run to completion and keep only the first failure.
- `CLK`  in  1  single clock, rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `START`  in  1  level-sampled; begins a test when in IDLE or DONE.
- `WE`  out  ADDR/DATA-independent 1  RAM write enable.
- `ADDR`  out  ADDR_WIDTH  RAM write address.
- `ADDR2`  out  ADDR_WIDTH  RAM read address; always equal to `ADDR`.
- `DIN`  out  DATA_WIDTH  RAM write data.
- `DOUT`  in  DATA_WIDTH  RAM read data.
- `BUSY`  out  1  test running.
- `DONE`  out  1  test finished; held until the next accepted START.
- `PASS`  out  1  valid while DONE; 1 = no miscompare.
- `FAIL_ADDR`  out  ADDR_WIDTH  address of the first miscompare.
- `FAIL_EXP`  out  DATA_WIDTH  expected word at the first miscompare.
- `FAIL_GOT`  out  DATA_WIDTH  received word at the first miscompare.

## Operation
- Pattern P: bit i = i[0], i.e. alternating 1 on odd bit positions (DATA_WIDTH=5 gives P=5'h0A). ~P = bitwise inverse (5'h15).
- The FSM runs through these states in order: IDLE → M0 → M1 → M2 → M3 → DRAIN → DONE.
  - M0: addresses ascend 0..N-1; write P, no compare.
  - M1: addresses ascend; read and expect P, and in the same cycle write ~P to the same address.
  - M2: addresses descend N-1..0; read and expect ~P, and write P.
  - M3: addresses ascend; read and expect P, with WE=0.
- Read and write of the same address in one cycle are legal. The RAM returns pre-write data: the next-cycle value when SYNC_READ=1, the current-cycle value when SYNC_READ=0.
- Each state lasts exactly N cycles. The address counter wraps at the state boundary, reloading 0 for ascending states and N-1 for descending states.
- DRAIN lasts SYNC_READ cycles (0 cycles means it is skipped). It completes the final compare.
- Compare stage: the expected word and address are delayed by SYNC_READ cycles and compared against DOUT.
  - The first miscompare latches FAIL_ADDR, FAIL_EXP, FAIL_GOT and sets an internal fail flag.
  - Later miscompares are ignored.
- STOP_ON_FAIL=1: on a miscompare, WE is deasserted that cycle and the FSM goes directly to DONE on the next edge.
- In DONE, PASS = !fail flag.
- START in IDLE or DONE is accepted: the fail flag and FAIL_* are cleared and the FSM enters M0. START in any other state is ignored.

## Timing
- Reset (asynchronous, immediate): WE=0, ADDR=ADDR2=0, DIN=0, BUSY=0, DONE=0, PASS=0, FAIL_*=0, FSM=IDLE, pipeline cleared.
- Reset asserted mid-test aborts with no further writes. The test restarts only on a new START after RST_N deasserts.
- START high at edge k gives BUSY=1 and the first M0 write (ADDR=0) during cycle k+1.
- Passing run: BUSY is high for exactly 4N+SYNC_READ cycles, then DONE=1 and BUSY=0 on the same edge.
- All RAM-side outputs are registered. `ADDR2` mirrors `ADDR` combinationally from the same register.
- Compare for the address issued in cycle c is evaluated in cycle c+SYNC_READ. FAIL_* are visible the cycle after that.
- Write count for a complete run is 3N (M0, M1, M2).

## Structure
- Package `bram_bist_pkg` holds:
  - the state enum (IDLE, M0, M1, M2, M3, DRAIN, DONE);
  - a pattern function `bist_pattern(width)`;
  - per-state constants: direction, expect-inverted, write-enable, write-inverted.
- Sub-module `bram_bist_cmp` holds:
  - the SYNC_READ-deep delay of {valid, addr, expected};
  - the comparator;
  - first-fail capture registers.
- The top level holds the FSM, address counter and RAM drive.

## Test plan
- Reset: hold RST_N=0 with START=1.
  - Required: all outputs at their reset values, and no WE pulse.
- Good RAM, `ram` instance with ADDR_WIDTH=4, DATA_WIDTH=5, SYNC_READ=1: pulse START.
  - Required: BUSY for 65 cycles, 48 WE cycles, then DONE=1, PASS=1, FAIL_*=0.
- Same bench with SYNC_READ=0 on both the RAM and the BIST.
  - Required: BUSY for 64 cycles, PASS=1.
- Stuck-at-1 on DOUT bit 0 at address 5, STOP_ON_FAIL=1.
  - Required: the first M1 compare at address 5 fails, giving FAIL_ADDR=5, FAIL_EXP=5'h0A, FAIL_GOT=5'h0B.
  - Required: DONE=1 and PASS=0 before M2 starts, with no writes after the failure.
- Same fault with STOP_ON_FAIL=0.
  - Required: the run completes the full 65 cycles.
  - Required: FAIL_* still hold the M1 address-5 values, and PASS=0.
- RST_N low for 1 cycle during M2, then START.
  - Required: outputs reset asynchronously.
  - Required: a fresh full run with PASS=1.
  - Required: START pulses during BUSY have no effect.
  - Required: START in DONE clears PASS/FAIL_* and restarts.

Source files
------------

// File: rtl/bram_bist_pkg.sv
// bram_bist_pkg: march states, checkerboard pattern and per-state march attributes for bram_bist
package bram_bist_pkg;
  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DRAIN, S_DONE} state_t;
  localparam logic [6:0] ST_MARCH = 7'b0011110;
  localparam logic [6:0] ST_CMP = 7'b0011100;
  localparam logic [6:0] ST_DOWN = 7'b0001000;
  localparam logic [6:0] ST_EXP_INV = 7'b0001000;
  localparam logic [6:0] ST_WE = 7'b0001110;
  localparam logic [6:0] ST_WR_INV = 7'b0000100;
  function automatic logic [31:0] bist_pattern(input int width);
    logic [31:0] p;
    p = '0;
    for (int i = 1; i < width && i < 32; i += 2) p[i] = 1'b1;
    return p;
  endfunction
endpackage

// File: rtl/bram_bist_cmp.sv
// bram_bist_cmp: SYNC_READ-deep delay of {valid,addr,expected}, readback comparator, first-fail capture
module bram_bist_cmp #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 10,
  parameter int SYNC_READ = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_exp,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  mis,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got
);
  logic d_valid;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_exp;
  if (SYNC_READ != 0) begin : g_dly
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        d_valid <= 1'b0;
        d_addr <= '0;
        d_exp <= '0;
      end else begin
        d_valid <= in_valid;
        d_addr <= in_addr;
        d_exp <= in_exp;
      end
  end else begin : g_comb
    assign d_valid = in_valid;
    assign d_addr = in_addr;
    assign d_exp = in_exp;
  end
  assign mis = d_valid && dout != d_exp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || clr) begin
      fail <= 1'b0;
      fail_addr <= '0;
      fail_exp <= '0;
      fail_got <= '0;
    end else if (mis && !fail) begin
      fail <= 1'b1;
      fail_addr <= d_addr;
      fail_exp <= d_exp;
      fail_got <= dout;
    end
endmodule

// File: rtl/bram_bist.sv
// bram_bist: march-test BIST for a block RAM (drives WE/ADDR/ADDR2/DIN, checks DOUT; START in, BUSY/DONE/PASS/FAIL_* out)
module bram_bist
  import bram_bist_pkg::*;
#(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 10,
  parameter int SYNC_READ = 1,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [ADDR_WIDTH-1:0] ADDR2,
  output logic [DATA_WIDTH-1:0] DIN,
  input  logic [DATA_WIDTH-1:0] DOUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  PASS,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [DATA_WIDTH-1:0] FAIL_EXP,
  output logic [DATA_WIDTH-1:0] FAIL_GOT
);
  localparam logic [DATA_WIDTH-1:0] P = DATA_WIDTH'(bist_pattern(DATA_WIDTH));
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] din_nx;
  logic we_q, mis, fail, clr, stop, last;
  always_comb begin
    clr = (state == S_IDLE || state == S_DONE) && START;
    stop = STOP_ON_FAIL != 0 && mis;
    last = ST_DOWN[state] ? ADDR == '0 : &ADDR;
    state_nx = state;
    if (clr) state_nx = S_M0;
    else if (stop || state == S_DRAIN) state_nx = S_DONE;
    else if (ST_MARCH[state] && last) state_nx = state != S_M3 ? state_t'(state + 3'd1) : SYNC_READ != 0 ? S_DRAIN : S_DONE;
    addr_nx = state_nx != state ? (ST_DOWN[state_nx] ? '1 : '0) : !ST_MARCH[state] ? ADDR : ST_DOWN[state] ? ADDR - ADDR_WIDTH'(1) : ADDR + ADDR_WIDTH'(1);
    din_nx = !ST_WE[state_nx] ? '0 : ST_WR_INV[state_nx] ? ~P : P;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= S_IDLE;
      ADDR <= '0;
      we_q <= 1'b0;
      DIN <= '0;
    end else begin
      state <= state_nx;
      ADDR <= addr_nx;
      we_q <= ST_WE[state_nx];
      DIN <= din_nx;
    end
  // an aborting miscompare suppresses the write already scheduled for this cycle
  assign WE = we_q && !stop;
  assign ADDR2 = ADDR;
  assign BUSY = state != S_IDLE && state != S_DONE;
  assign DONE = state == S_DONE;
  assign PASS = DONE && !fail;
  bram_bist_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .SYNC_READ(SYNC_READ)
  ) u_cmp (
    .clk(CLK),
    .rst_n(RST_N),
    .clr(clr),
    .in_valid(ST_CMP[state]),
    .in_addr(ADDR),
    .in_exp(ST_EXP_INV[state] ? ~P : P),
    .dout(DOUT),
    .mis(mis),
    .fail(fail),
    .fail_addr(FAIL_ADDR),
    .fail_exp(FAIL_EXP),
    .fail_got(FAIL_GOT)
  );
endmodule

// File: tb/tb_bram_bist.sv
// tb_bram_bist: three bram_bist instances (sync/stop, comb/stop, sync/run-on) on RAM models checked against a march model
module tb_bram_bist;
  localparam int N = 16;
  localparam logic [4:0] P = 5'h0A;
  localparam logic [4:0] NP = 5'h15;
  localparam int SRA [3] = '{1, 0, 1};
  localparam int SOFA [3] = '{1, 1, 0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start [3];
  logic fault [3];
  logic we [3], busy [3], done [3], pass [3];
  logic [3:0] addr [3], addr2 [3], fa [3];
  logic [4:0] din [3], dout [3], fe [3], fg [3];
  int t [3] = '{-1, -1, -1};
  int tf [3] = '{-1, -1, -1};
  int bc [3] = '{0, 0, 0};
  int wc [3] = '{0, 0, 0};
  int n_vec = 0;
  int n_mis = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : gi
    logic [4:0] mem [16];
    logic [4:0] rdq, rd;
    assign rd = mem[addr2[g]] | {4'd0, fault[g] && addr2[g] == 4'd5};
    always @(posedge clk) begin
      if (we[g]) mem[addr[g]] <= din[g];
      rdq <= rd;
    end
    assign dout[g] = (g == 1) ? rd : rdq;
    bram_bist #(
      .DATA_WIDTH(5),
      .ADDR_WIDTH(4),
      .SYNC_READ(g == 1 ? 0 : 1),
      .STOP_ON_FAIL(g == 2 ? 0 : 1)
    ) dut (
      .CLK(clk), .RST_N(rst_n), .START(start[g]), .WE(we[g]), .ADDR(addr[g]), .ADDR2(addr2[g]),
      .DIN(din[g]), .DOUT(dout[g]), .BUSY(busy[g]), .DONE(done[g]), .PASS(pass[g]),
      .FAIL_ADDR(fa[g]), .FAIL_EXP(fe[g]), .FAIL_GOT(fg[g])
    );
  end
  function automatic int ph(input int x);
    return x / N;
  endfunction
  function automatic logic [3:0] addr_of(input int x);
    return 4'(ph(x) == 2 ? N - 1 - x % N : x % N);
  endfunction
  function automatic logic [4:0] exp_of(input int x);
    return ph(x) == 2 ? NP : P;
  endfunction
  function automatic logic [4:0] din_of(input int x);
    return ph(x) == 1 ? NP : P;
  endfunction
  function automatic int first_fail(input logic f);
    for (int x = N; x < 4 * N; x++)
      if (f && addr_of(x) == 4'd5 && (exp_of(x) | 5'd1) != exp_of(x)) return x;
    return -1;
  endfunction
  function automatic int end_t(input int g);
    return (SOFA[g] != 0 && tf[g] >= 0) ? tf[g] + SRA[g] + 1 : 4 * N + SRA[g];
  endfunction
  function automatic logic wr_exp(input int g, input int x);
    return x < 3 * N && !(SOFA[g] != 0 && tf[g] >= 0 && x >= tf[g] + SRA[g]);
  endfunction
  task automatic chk(input string nm, input int g, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s[%0d] t=%0d: got %0h expected %0h", nm, g, t[g], got, exp);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    for (int g = 0; g < 3; g++)
      if (!rst_n) t[g] <= -1;
      else if (start[g] && (t[g] < 0 || t[g] >= end_t(g))) begin
        t[g] <= 0;
        tf[g] <= first_fail(fault[g]);
      end else if (t[g] >= 0 && t[g] < end_t(g)) t[g] <= t[g] + 1;
  always @(negedge clk)
    for (int g = 0; g < 3; g++) begin
      if (!rst_n || t[g] < 0) begin
        chk("we", g, we[g], 0);
        chk("busy", g, busy[g], 0);
        chk("done", g, done[g], 0);
        chk("pass", g, pass[g], 0);
        chk("addr", g, addr[g], 0);
        chk("din", g, din[g], 0);
        chk("fail_addr", g, fa[g], 0);
        chk("fail_exp", g, fe[g], 0);
        chk("fail_got", g, fg[g], 0);
      end else begin
        logic act, fv;
        act = t[g] < end_t(g);
        fv = tf[g] >= 0 && t[g] > tf[g] + SRA[g];
        if (t[g] == 0) begin
          bc[g] = 0;
          wc[g] = 0;
        end
        bc[g] += int'(busy[g]);
        wc[g] += int'(we[g]);
        chk("busy", g, busy[g], act);
        chk("done", g, done[g], !act);
        chk("pass", g, pass[g], !act && tf[g] < 0);
        chk("we", g, we[g], act && wr_exp(g, t[g]));
        if (act) begin
          chk("addr", g, addr[g], addr_of(t[g]));
          chk("addr2", g, addr2[g], addr_of(t[g]));
          if (wr_exp(g, t[g])) chk("din", g, din[g], din_of(t[g]));
        end
        chk("fail_addr", g, fa[g], fv ? addr_of(tf[g]) : 0);
        chk("fail_exp", g, fe[g], fv ? exp_of(tf[g]) : 0);
        chk("fail_got", g, fg[g], fv ? (exp_of(tf[g]) | 5'd1) : 0);
      end
    end
  task automatic pulse(input logic [2:0] m);
    for (int g = 0; g < 3; g++) start[g] = m[g];
    @(negedge clk);
    for (int g = 0; g < 3; g++) start[g] = 1'b0;
  endtask
  task automatic wait_done(input int g);
    int n;
    n = 0;
    while (!done[g] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", g, done[g], 1);
  endtask
  task automatic final_chk(input int g, input int busy_n, input int we_n, input logic ok);
    chk("busy_cycles", g, bc[g], busy_n);
    chk("we_cycles", g, wc[g], we_n);
    chk("final_pass", g, pass[g], ok);
    chk("final_fail_addr", g, fa[g], ok ? 0 : 5);
    chk("final_fail_exp", g, fe[g], ok ? 0 : 5'h0A);
    chk("final_fail_got", g, fg[g], ok ? 0 : 5'h0B);
  endtask
  initial begin
    for (int g = 0; g < 3; g++) begin
      start[g] = 1'b1;
      fault[g] = 1'b0;
    end
    repeat (4) @(negedge clk);
    for (int g = 0; g < 3; g++) start[g] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(3'b111);
    for (int g = 0; g < 3; g++) wait_done(g);
    final_chk(0, 65, 48, 1'b1);
    final_chk(1, 64, 48, 1'b1);
    final_chk(2, 65, 48, 1'b1);
    fault[0] = 1'b1;
    fault[2] = 1'b1;
    pulse(3'b101);
    wait_done(0);
    final_chk(0, 23, 22, 1'b0);
    wait_done(2);
    final_chk(2, 65, 48, 1'b0);
    fault[0] = 1'b0;
    fault[2] = 1'b0;
    pulse(3'b001);
    repeat (10) @(negedge clk);
    pulse(3'b001);
    repeat (28) @(negedge clk);
    chk("in_m2_busy", 0, busy[0], 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_we", 0, we[0], 0);
    chk("arst_busy", 0, busy[0], 0);
    chk("arst_addr", 0, addr[0], 0);
    chk("arst_din", 0, din[0], 0);
    chk("arst_done", 1, done[1], 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    pulse(3'b001);
    wait_done(0);
    final_chk(0, 65, 48, 1'b1);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
